alien_fleet_controller: RTL and testbench
=========================================

// Module: alien_fleet_controller
// PURPOSE
//  Sequences the alien formation for the Space Invaders game. It owns the fleet origin, march
//  direction, alive mask, march speed and the win/lost flags. The top level consumes these outputs
//  to drive the alien/bullet sprite logic and select the screen colour.
//  Advances only on the one-cycle frame pulse (update). Collision hits arrive as per-alien pulses.
// PARAMETERS
//  NUM_ALIENS   8    aliens in one row; width of alive/hit
//  ALIEN_W      40   alien sprite width, px
//  ALIEN_H      24   alien sprite height, px
//  ALIEN_PITCH  60   x distance between alien origins, px; FLEET_W=(NUM_ALIENS-1)*PITCH+ALIEN_W=460
//  X_MIN        10   left playfield limit (inside border)
//  X_MAX        631  right playfield limit (border start)
//  START_X      20   fleet_x after reset/restart
//  START_Y      40   fleet_y after reset/restart
//  STEP_X       4    px per march step
//  DROP_Y       16   px per descent
//  LOSE_Y       400  fleet bottom reaching this row => lost
//  BASE_PERIOD  30   frames per step with 0 kills
//  PERIOD_DEC   4    frames removed per kill
//  MIN_PERIOD   3    floor for step period
// PORTS
//  VGA_clk   in   1           sole clock (25 MHz pixel clock)
//  rst       in   1           synchronous, active-high reset
//  update    in   1           frame tick, 1-cycle pulse
//  start     in   1           start/restart request (level sampled each cycle)
//  hit       in   NUM_ALIENS  per-alien kill pulse from collision logic
//  fleet_x   out  10          x of alien 0 origin
//  fleet_y   out  10          y of fleet origin
//  alive     out  NUM_ALIENS  1 = alien present
//  dir_left  out  1           0 = marching right, 1 = left
//  win       out  1           all aliens killed
//  lost      out  1           fleet reached LOSE_Y
//  fsm_state out  3           IDLE=0 MARCH=1 DROP=2 WON=3 LOST=4 (debug)
// BEHAVIOUR
//  - Reset (sync, priority over all): IDLE, fleet_x=START_X, fleet_y=START_Y, alive=all 1,
//    dir_left=0, win=0, lost=0, frame_cnt=0. Reset mid-game gives the same result.
//  - All outputs are registered. A change is visible the cycle after the triggering input.
//  - IDLE: hold. start=1 -> MARCH with frame_cnt=0.
//  - MARCH: on update, if frame_cnt==period-1 then step and clear frame_cnt, else frame_cnt++.
//      Right step: if fleet_x+FLEET_W+STEP_X > X_MAX -> DROP (x unchanged, dir_left<=1),
//      else fleet_x+=STEP_X.
//      Left step: if fleet_x < X_MIN+STEP_X -> DROP (dir_left<=0), else fleet_x-=STEP_X.
//      Edge compare uses 11-bit arithmetic. No 10-bit wrap is allowed.
//  - DROP: lasts exactly 1 cycle. fleet_y+=DROP_Y. If new fleet_y+ALIEN_H >= LOSE_Y -> LOST
//    (lost<=1), else MARCH. frame_cnt stays 0.
//  - period = max(MIN_PERIOD, BASE_PERIOD - PERIOD_DEC*kills), where kills = NUM_ALIENS -
//    popcount(alive). Compute with signed/wide math so no underflow. A new period applies at the
//    next compare. If frame_cnt is already >= the new period-1, step on the next update.
//  - Hits are honoured in MARCH and DROP only: alive <= alive & ~hit. Hits on dead aliens are no-ops.
//    Multiple simultaneous hits are all applied.
//  - If the alive mask becomes 0 -> WON (win<=1). WON has priority over a same-cycle LOST or DROP.
//    A same-cycle update step is discarded.
//  - A hit and an update in the same cycle: both take effect. The period uses the pre-hit kill count.
//  - WON/LOST: all outputs frozen, hit and update ignored. start=1 -> full re-init (reset values)
//    and go directly to MARCH.
//  - win and lost are never both 1.
// STRUCTURE
//  - space_invaders_pkg: NUM_ALIENS, playfield limits X_MIN/X_MAX/LOSE_Y, fsm state localparams,
//    popcount function.
//  - Sub-module march_timer: frame counter with a programmable period. Inputs update, clr, period.
//    Output step pulse.
//  - Remainder: FSM + position/alive registers in this file.
// TESTING
//  1. rst=1 for 2 cycles -> fleet_x=20, fleet_y=40, alive=8'hFF, state IDLE. 100 updates with
//     start=0 -> no change.
//  2. start, no hits -> fleet_x=24 after update #30. After update #1110 fleet_x=168. Update #1140
//     -> DROP for 1 cycle, then fleet_y=56, dir_left=1.
//  3. kill 3 aliens (hit=8'h07) -> period 18. Next step is 18 updates after the previous step.
//     Kill 7 -> period clamps to 3.
//  4. hit=8'h80 and 8'h7F on separate cycles -> win=1 next cycle. Further updates leave
//     fleet_x/fleet_y frozen.
//  5. no hits, force 21 drops -> on the 21st, fleet_y=376 and lost=1, win=0. A hit while LOST ->
//     alive unchanged.
//  6. in LOST assert start -> MARCH with reset values. rst during MARCH mid-count -> IDLE values
//     next cycle.

Source files
------------

// File: rtl/space_invaders_pkg.sv
// Shared constants, FSM encoding and helpers for the alien fleet logic.
package space_invaders_pkg;
    localparam int NUM_ALIENS  = 8;
    localparam int ALIEN_W     = 40;
    localparam int ALIEN_H     = 24;
    localparam int ALIEN_PITCH = 60;
    localparam int FLEET_W     = (NUM_ALIENS - 1) * ALIEN_PITCH + ALIEN_W;
    localparam int X_MIN       = 10;
    localparam int X_MAX       = 631;
    localparam int START_X     = 20;
    localparam int START_Y     = 40;
    localparam int STEP_X      = 4;
    localparam int DROP_Y      = 16;
    localparam int LOSE_Y      = 400;
    localparam int BASE_PERIOD = 30;
    localparam int PERIOD_DEC  = 4;
    localparam int MIN_PERIOD  = 3;
    localparam int PERIOD_W    = 6;
    localparam int CNT_W       = $clog2(NUM_ALIENS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MARCH = 3'd1,
        ST_DROP  = 3'd2,
        ST_WON   = 3'd3,
        ST_LOST  = 3'd4
    } fleet_state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ALIENS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_ALIENS; i++)
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/alien_fleet_controller_march_timer.sv
// Frame counter: emits a step pulse on the update that completes a period.
module march_timer
    import space_invaders_pkg::*;
(
    input  logic                VGA_clk,
    input  logic                rst,
    input  logic                update,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);
    logic [PERIOD_W-1:0] frame_cnt;

    // >= rather than == so a period that shrinks below the count fires immediately
    assign step = update && !clr && (frame_cnt >= period - PERIOD_W'(1));

    // Count updates, wrap to zero on a step, hold zero while cleared
    always_ff @(posedge VGA_clk) begin
        if (rst || clr)  frame_cnt <= '0;
        else if (step)   frame_cnt <= '0;
        else if (update) frame_cnt <= frame_cnt + PERIOD_W'(1);
    end
endmodule

// File: rtl/alien_fleet_controller.sv
// Alien formation sequencer: march/drop FSM, fleet position, alive mask, win/lost.
module alien_fleet_controller
    import space_invaders_pkg::*;
(
    input  logic                  VGA_clk,
    input  logic                  rst,
    input  logic                  update,
    input  logic                  start,
    input  logic [NUM_ALIENS-1:0] hit,
    output logic [9:0]            fleet_x,
    output logic [9:0]            fleet_y,
    output logic [NUM_ALIENS-1:0] alive,
    output logic                  dir_left,
    output logic                  win,
    output logic                  lost,
    output logic [2:0]            fsm_state
);
    fleet_state_t state, state_n;
    logic [9:0]            x_n, y_n, y_drop;
    logic [NUM_ALIENS-1:0] alive_n, alive_hit;
    logic                  dir_n, win_n, lost_n;
    logic                  step, hits_ok, all_dead, at_edge, lose;
    logic [PERIOD_W-1:0]   period;
    int                    kills, raw_period;

    // Period from the pre-hit kill count, signed so heavy losses clamp instead of wrapping
    always_comb begin
        kills      = NUM_ALIENS - int'(popcount(alive));
        raw_period = BASE_PERIOD - PERIOD_DEC * kills;
        period     = (raw_period < MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : PERIOD_W'(raw_period);
    end

    march_timer u_timer (
        .VGA_clk (VGA_clk),
        .rst     (rst),
        .update  (update),
        .clr     (state != ST_MARCH),
        .period  (period),
        .step    (step)
    );

    // Edge, kill and descent conditions; 11-bit compares keep the border test from wrapping
    always_comb begin
        hits_ok   = (state == ST_MARCH) || (state == ST_DROP);
        alive_hit = alive & ~hit;
        all_dead  = hits_ok && (alive_hit == '0);
        if (dir_left) at_edge = {1'b0, fleet_x} < 11'(X_MIN + STEP_X);
        else          at_edge = ({1'b0, fleet_x} + 11'(FLEET_W + STEP_X)) > 11'(X_MAX);
        y_drop = fleet_y + 10'(DROP_Y);
        lose   = ({1'b0, y_drop} + 11'(ALIEN_H)) >= 11'(LOSE_Y);
    end

    // State register
    always_ff @(posedge VGA_clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state; a wipe-out beats any same-cycle step, drop or loss
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_MARCH;
            ST_MARCH: begin
                if (all_dead)             state_n = ST_WON;
                else if (step && at_edge) state_n = ST_DROP;
            end
            ST_DROP: begin
                if (all_dead)  state_n = ST_WON;
                else if (lose) state_n = ST_LOST;
                else           state_n = ST_MARCH;
            end
            ST_WON, ST_LOST: if (start) state_n = ST_MARCH;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        x_n     = fleet_x;
        y_n     = fleet_y;
        alive_n = alive;
        dir_n   = dir_left;
        win_n   = win;
        lost_n  = lost;
        case (state)
            ST_MARCH: begin
                alive_n = alive_hit;
                if (all_dead) win_n = 1'b1;
                else if (step) begin
                    if (at_edge)       dir_n = ~dir_left;
                    else if (dir_left) x_n   = fleet_x - 10'(STEP_X);
                    else               x_n   = fleet_x + 10'(STEP_X);
                end
            end
            ST_DROP: begin
                alive_n = alive_hit;
                if (all_dead) win_n = 1'b1;
                else begin
                    y_n = y_drop;
                    if (lose) lost_n = 1'b1;
                end
            end
            ST_WON, ST_LOST: begin
                if (start) begin
                    x_n     = 10'(START_X);
                    y_n     = 10'(START_Y);
                    alive_n = '1;
                    dir_n   = 1'b0;
                    win_n   = 1'b0;
                    lost_n  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            fleet_x  <= 10'(START_X);
            fleet_y  <= 10'(START_Y);
            alive    <= '1;
            dir_left <= 1'b0;
            win      <= 1'b0;
            lost     <= 1'b0;
        end else begin
            fleet_x  <= x_n;
            fleet_y  <= y_n;
            alive    <= alive_n;
            dir_left <= dir_n;
            win      <= win_n;
            lost     <= lost_n;
        end
    end

    assign fsm_state = state;
endmodule

// File: tb/tb_alien_fleet_controller.sv
// Randomized and directed bench for alien_fleet_controller against a behavioural model.
module tb_alien_fleet_controller;
    logic       VGA_clk = 0;
    logic       rst = 1, update = 0, start = 0;
    logic [7:0] hit = '0;
    logic [9:0] fleet_x, fleet_y;
    logic [7:0] alive;
    logic       dir_left, win, lost;
    logic [2:0] fsm_state;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    // model: counts updates since the last step; "dropping" is a pending descent
    int m_x, m_y, m_cnt;
    bit m_dir, m_win, m_lost, m_run, m_drop;
    logic [7:0] m_alive;

    alien_fleet_controller dut (
        .VGA_clk(VGA_clk), .rst(rst), .update(update), .start(start), .hit(hit),
        .fleet_x(fleet_x), .fleet_y(fleet_y), .alive(alive), .dir_left(dir_left),
        .win(win), .lost(lost), .fsm_state(fsm_state)
    );

    always #5 VGA_clk = ~VGA_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 20; m_y = 40; m_alive = 8'hFF; m_dir = 0;
        m_win = 0; m_lost = 0; m_drop = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic u, input logic s, input logic [7:0] h, input logic r);
        int per;
        logic [7:0] na;
        if (r) begin model_reset(); m_run = 0; return; end
        if (!m_run) begin if (s) m_run = 1; return; end
        if (m_win || m_lost) begin
            if (s) model_reset();
            return;
        end
        per = 30 - 4 * (8 - $countones(m_alive));
        if (per < 3) per = 3;
        na = m_alive & ~h;
        if (na == 0) begin m_alive = 0; m_win = 1; m_drop = 0; return; end
        m_alive = na;
        if (m_drop) begin
            m_drop = 0; m_y += 16; m_cnt = 0;
            if (m_y + 24 >= 400) m_lost = 1;
            return;
        end
        if (u) begin
            m_cnt++;
            if (m_cnt >= per) begin
                m_cnt = 0;
                if (!m_dir) begin
                    if (m_x + 460 + 4 > 631) begin m_dir = 1; m_drop = 1; end
                    else m_x += 4;
                end else begin
                    if (m_x - 4 < 10) begin m_dir = 0; m_drop = 1; end
                    else m_x -= 4;
                end
            end
        end
    endtask

    function automatic int model_state();
        if (!m_run) return 0;
        if (m_win)  return 3;
        if (m_lost) return 4;
        if (m_drop) return 2;
        return 1;
    endfunction

    // Every cycle: DUT outputs against the model
    always @(negedge VGA_clk) begin
        if (chk_en) begin
            chk("fleet_x", fleet_x, m_x);
            chk("fleet_y", fleet_y, m_y);
            chk("alive", alive, m_alive);
            chk("dir_left", dir_left, m_dir);
            chk("win", win, m_win);
            chk("lost", lost, m_lost);
            chk("fsm_state", fsm_state, model_state());
        end
    end

    task automatic cycle(input logic u, input logic s, input logic [7:0] h, input logic r);
        update = u; start = s; hit = h; rst = r;
        @(posedge VGA_clk);
        model_step(u, s, h, r);
        @(negedge VGA_clk);
    endtask

    task automatic updates_to_step(output int n);
        int x0;
        x0 = fleet_x; n = 0;
        while (fleet_x == x0 && n < 200) begin cycle(1, 0, 8'h00, 0); n++; end
    endtask

    initial begin
        int n, drops, sx, sy;
        m_run = 0; model_reset();
        @(negedge VGA_clk);
        // 1. reset and idle hold
        cycle(0, 0, 8'h00, 1);
        chk_en = 1;
        cycle(0, 0, 8'h00, 1);
        chk("rst_x", fleet_x, 20); chk("rst_y", fleet_y, 40);
        chk("rst_alive", alive, 8'hFF); chk("rst_state", fsm_state, 0);
        for (int i = 0; i < 100; i++) cycle(1, 0, 8'h00, 0);
        chk("idle_x", fleet_x, 20); chk("idle_state", fsm_state, 0);
        // 2. march to the right edge
        cycle(0, 1, 8'h00, 0);
        for (int i = 1; i <= 1140; i++) begin
            cycle(1, 0, 8'h00, 0);
            if (i == 30)   chk("x_after_30", fleet_x, 24);
            if (i == 1110) chk("x_after_1110", fleet_x, 168);
        end
        chk("drop_state", fsm_state, 2);
        cycle(0, 0, 8'h00, 0);
        chk("drop_y", fleet_y, 56); chk("drop_dir", dir_left, 1); chk("after_drop_state", fsm_state, 1);
        // 3. kill 3 -> period 18, kill 7 -> period 3
        cycle(0, 0, 8'h07, 0);
        updates_to_step(n);
        updates_to_step(n);
        chk("period_3_kills", n, 18);
        cycle(0, 0, 8'h78, 0);
        updates_to_step(n);
        updates_to_step(n);
        chk("period_7_kills", n, 3);
        // 4. last alien -> win, frozen afterwards
        cycle(0, 0, 8'h80, 0);
        chk("win", win, 1); chk("win_lost", lost, 0); chk("win_state", fsm_state, 3);
        sx = fleet_x; sy = fleet_y;
        for (int i = 0; i < 50; i++) cycle(1, 0, 8'(i), 0);
        chk("won_frozen_x", fleet_x, sx); chk("won_frozen_y", fleet_y, sy);
        // 5. restart, march until lost
        cycle(0, 1, 8'h00, 0);
        chk("restart_x", fleet_x, 20); chk("restart_alive", alive, 8'hFF); chk("restart_win", win, 0);
        drops = 0; n = 0;
        while (!lost && n < 40000) begin
            cycle(1, 0, 8'h00, 0);
            if (fsm_state == 2) drops++;
            n++;
        end
        chk("lost_timeout", (n < 40000) ? 1 : 0, 1);
        chk("lost_drops", drops, 21); chk("lost_y", fleet_y, 376);
        chk("lost_flag", lost, 1); chk("lost_win", win, 0);
        cycle(1, 0, 8'hFF, 0);
        chk("lost_hit_ignored", alive, 8'hFF);
        // 6. restart from lost, reset mid-count
        cycle(0, 1, 8'h00, 0);
        chk("relaunch_state", fsm_state, 1); chk("relaunch_y", fleet_y, 40); chk("relaunch_lost", lost, 0);
        for (int i = 0; i < 15; i++) cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 1);
        chk("midrst_state", fsm_state, 0); chk("midrst_x", fleet_x, 20);
        // 7. random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] h;
            h = ($urandom_range(0, 40) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 150) == 0) h = 8'($urandom);
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 120) == 0, h,
                  $urandom_range(0, 1500) == 0);
        end
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
